// File: rtl/opb_register_bank_ppc2simulink.sv
//==============================================================================
// Module      : opb_register_bank_ppc2simulink
// Description : OPB slave bank of C_NUM_REGS PowerPC-writable control registers
//               feeding Simulink user logic. It provides byte-enable writes,
//               readback, write strobes and self-clearing pulse registers.
//               Optional macro REG_SHADOW_EN adds an atomic shadow/commit mode.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]           C_BASEADDR   = 32'h00000000,
  parameter logic [31:0]           C_HIGHADDR   = 32'h000000FF,
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32,
  parameter int                    C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
  parameter logic [31:0]           C_RESET_VAL  = 32'h0,
  parameter string                 C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_stb
);

  localparam logic [29:0] c_num_regs = 30'(C_NUM_REGS);

  // OPB bit 0 is the MSB, so plain assignment to [31:0] vectors maps it to bit 31
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [31:0] w_offset;
  logic [29:0] w_idx;
  logic [31:0] w_mask;
  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  logic [C_NUM_REGS-1:0] w_sel;
  logic [31:0] w_base   [C_NUM_REGS];
  logic [31:0] w_merged [C_NUM_REGS];
  logic [31:0] w_rdata;

  logic                  r_ack;
  logic [31:0]           r_rdata;
  logic [31:0]           r_out [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] r_stb;

`ifdef REG_SHADOW_EN
  logic [31:0]           r_shadow [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] r_dirty;
  logic                  w_commit;
`endif

  assign w_addr   = OPB_ABus;
  assign w_wdata  = OPB_DBus;
  assign w_be     = OPB_BE;
  assign w_offset = w_addr - C_BASEADDR;
  assign w_idx    = w_offset[31:2];
  assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};

  assign w_hit = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR) && !r_ack;
  assign w_wr  = w_hit && !OPB_RNW;
  assign w_rd  = w_hit && OPB_RNW;

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, OPB_seqAddr, w_offset[1:0],
                         (C_OPB_AWIDTH == 32), (C_OPB_DWIDTH == 32), (C_FAMILY == "")};

  generate
    for (genvar gi = 0; gi < C_NUM_REGS; gi++) begin : g_reg
      assign w_sel[gi] = (w_idx == 30'(gi));
      assign user_data_out[32*gi +: 32] = r_out[gi];
    end
  endgenerate

`ifdef REG_SHADOW_EN
  assign w_commit = w_wr && (w_idx == c_num_regs) && w_be[0] && w_wdata[0];
`endif

  // Pulse registers merge against zero and always read back as zero
  always_comb begin
    for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef REG_SHADOW_EN
      w_base[i] = C_PULSE_MASK[i] ? 32'h0 : r_shadow[i];
`else
      w_base[i] = C_PULSE_MASK[i] ? 32'h0 : r_out[i];
`endif
      w_merged[i] = (w_base[i] & ~w_mask) | (w_wdata & w_mask);
    end
  end

  always_comb begin
    w_rdata = 32'h0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (w_sel[i]) begin
        w_rdata = w_base[i];
      end
    end
`ifdef REG_SHADOW_EN
    if (w_idx == c_num_regs) begin
      w_rdata = 32'(r_dirty);
    end
`endif
  end

  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
      r_stb   <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        r_out[i] <= C_PULSE_MASK[i] ? 32'h0 : C_RESET_VAL;
`ifdef REG_SHADOW_EN
        r_shadow[i] <= C_PULSE_MASK[i] ? 32'h0 : C_RESET_VAL;
`endif
      end
`ifdef REG_SHADOW_EN
      r_dirty <= '0;
`endif
    end else begin
      r_ack   <= w_hit;
      r_rdata <= w_rd ? w_rdata : 32'h0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
`ifdef REG_SHADOW_EN
        if (w_wr && w_sel[i]) begin
          r_shadow[i] <= w_merged[i];
          r_dirty[i]  <= 1'b1;
        end else if (w_commit) begin
          r_dirty[i]  <= 1'b0;
        end
        r_stb[i] <= w_commit && r_dirty[i];
        if (w_commit && r_dirty[i]) begin
          r_out[i] <= r_shadow[i];
        end else if (C_PULSE_MASK[i]) begin
          r_out[i] <= 32'h0;
        end
`else
        r_stb[i] <= w_wr && w_sel[i];
        if (w_wr && w_sel[i]) begin
          r_out[i] <= w_merged[i];
        end else if (C_PULSE_MASK[i]) begin
          r_out[i] <= 32'h0;
        end
`endif
      end
    end
  end

  assign Sl_DBus     = r_rdata;
  assign Sl_xferAck  = r_ack;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_wr_stb = r_stb;

endmodule

`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench: vector table driven through a read-data scoreboard,
// plus back-to-back pulse writes and a reset-aborted write.
`default_nettype none

module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         ack;
  logic         err;
  logic         retry;
  logic         tout;
  logic [127:0] udo;
  logic [3:0]   stb;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    bit           rnw;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  data;
    bit           exp_ack;
    logic [31:0]  exp_rd;
    logic [127:0] exp_out;
    logic [3:0]   exp_stb;
  } vec_t;

  vec_t vecs[$];

  opb_register_bank_ppc2simulink #(
    .C_NUM_REGS  (4),
    .C_PULSE_MASK(4'b1000),
    .C_RESET_VAL (32'hDEADBEEF)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq),
    .Sl_DBus      (sl_dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout),
    .user_data_out(udo),
    .user_wr_stb  (stb)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t v(input bit r, input logic [31:0] a, input logic [3:0] b,
                             input logic [31:0] d, input bit ea, input logic [31:0] erd,
                             input logic [127:0] eo, input logic [3:0] es);
    vec_t t;
    t.rnw = r; t.addr = a; t.be = b; t.data = d;
    t.exp_ack = ea; t.exp_rd = erd; t.exp_out = eo; t.exp_stb = es;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
  endtask

  // Drives one transaction; select stays high through T+1 as an OPB master would
  task automatic apply(input vec_t t, input string nm);
    logic [31:0] exp_rd;
    @(negedge clk);
    sel = 1'b1; rnw = t.rnw; abus = t.addr; be = t.be; dbus = t.data;
    if (t.exp_ack) sb_q.push_back(t.exp_rd);
    @(posedge clk); #1;
    chk({nm, ".ack"}, 128'(ack), 128'(t.exp_ack));
    if (ack && sb_q.size() > 0) begin
      exp_rd = sb_q.pop_front();
      chk({nm, ".rdata"}, 128'(sl_dbus), 128'(exp_rd));
    end else if (t.exp_ack && sb_q.size() > 0) begin
      void'(sb_q.pop_front());
    end
    chk({nm, ".out"}, udo, t.exp_out);
    chk({nm, ".stb"}, 128'(stb), 128'(t.exp_stb));
    @(negedge clk);
    @(posedge clk); #1;
    chk({nm, ".ack_end"}, 128'(ack), 128'(0));
    chk({nm, ".dbus_end"}, 128'(sl_dbus), 128'(0));
    chk({nm, ".stb_end"}, 128'(stb), 128'(0));
    chk({nm, ".out_end"}, udo, t.exp_out & ~mk(32'hFFFFFFFF, 0, 0, 0));
  endtask

  initial begin
    rst_n = 1'b0; seq = 1'b0;
    sel = 1'b0; rnw = 1'b0; abus = '0; be = '0; dbus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ack", 128'(ack), 128'(0));
    chk("reset.dbus", 128'(sl_dbus), 128'(0));
    chk("reset.stb", 128'(stb), 128'(0));
    chk("reset.out", udo, mk(0, DB, DB, DB));
    chk("reset.ties", 128'({err, retry, tout}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

`ifndef REG_SHADOW_EN
    vecs.push_back(v(1, 32'h08, 4'hF, 0,            1, DB,           mk(0, DB, DB, DB), 4'b0000));
    vecs.push_back(v(0, 32'h04, 4'b0110, 32'h12345678, 1, 0,         mk(0, DB, 32'hDE3456EF, DB), 4'b0010));
    vecs.push_back(v(1, 32'h04, 4'hF, 0,            1, 32'hDE3456EF, mk(0, DB, 32'hDE3456EF, DB), 4'b0000));
    vecs.push_back(v(0, 32'h0C, 4'hF, 32'h000000A5, 1, 0,            mk(32'hA5, DB, 32'hDE3456EF, DB), 4'b1000));
    vecs.push_back(v(1, 32'h0C, 4'hF, 0,            1, 0,            mk(0, DB, 32'hDE3456EF, DB), 4'b0000));
    vecs.push_back(v(0, 32'h24, 4'hF, 32'hFFFFFFFF, 1, 0,            mk(0, DB, 32'hDE3456EF, DB), 4'b0000));
    vecs.push_back(v(1, 32'h24, 4'hF, 0,            1, 0,            mk(0, DB, 32'hDE3456EF, DB), 4'b0000));
    vecs.push_back(v(0, 32'h10, 4'hF, 32'h00000001, 1, 0,            mk(0, DB, 32'hDE3456EF, DB), 4'b0000));
    vecs.push_back(v(0, 32'h01, 4'hF, 32'hCAFEF00D, 1, 0,            mk(0, DB, 32'hDE3456EF, 32'hCAFEF00D), 4'b0001));
    vecs.push_back(v(1, 32'h03, 4'hF, 0,            1, 32'hCAFEF00D, mk(0, DB, 32'hDE3456EF, 32'hCAFEF00D), 4'b0000));
    vecs.push_back(v(0, 32'h08, 4'b1000, 32'h11223344, 1, 0,         mk(0, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b0100));
    vecs.push_back(v(0, 32'h04, 4'hF, 32'hDE3456EF, 1, 0,            mk(0, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b0010));
    vecs.push_back(v(1, 32'h100, 4'hF, 0,           0, 0,            mk(0, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b0000));
    vecs.push_back(v(1, 32'h08, 4'hF, 0,            1, 32'h11ADBEEF, mk(0, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b0000));
`else
    vecs.push_back(v(0, 32'h00, 4'hF, 32'h11111111, 1, 0,            mk(0, DB, DB, DB), 4'b0000));
    vecs.push_back(v(0, 32'h08, 4'hF, 32'h22222222, 1, 0,            mk(0, DB, DB, DB), 4'b0000));
    vecs.push_back(v(1, 32'h10, 4'hF, 0,            1, 32'h5,        mk(0, DB, DB, DB), 4'b0000));
    vecs.push_back(v(0, 32'h10, 4'hF, 32'h00000001, 1, 0,            mk(0, 32'h22222222, DB, 32'h11111111), 4'b0101));
    vecs.push_back(v(1, 32'h10, 4'hF, 0,            1, 0,            mk(0, 32'h22222222, DB, 32'h11111111), 4'b0000));
    vecs.push_back(v(1, 32'h00, 4'hF, 0,            1, 32'h11111111, mk(0, 32'h22222222, DB, 32'h11111111), 4'b0000));
    vecs.push_back(v(0, 32'h0C, 4'hF, 32'h000000A5, 1, 0,            mk(0, 32'h22222222, DB, 32'h11111111), 4'b0000));
    vecs.push_back(v(0, 32'h10, 4'hF, 32'h00000001, 1, 0,            mk(32'hA5, 32'h22222222, DB, 32'h11111111), 4'b1000));
`endif

    foreach (vecs[i]) begin
      apply(vecs[i], $sformatf("vec%0d", i));
      idle();
    end

`ifndef REG_SHADOW_EN
    // Two pulse writes in consecutive transactions give two separate pulses
    apply(v(0, 32'h0C, 4'hF, 32'h000000A5, 1, 0,
            mk(32'hA5, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b1000), "pulse_a");
    apply(v(0, 32'h0C, 4'b0001, 32'h0000005A, 1, 0,
            mk(32'h5A, 32'h11ADBEEF, 32'hDE3456EF, 32'hCAFEF00D), 4'b1000), "pulse_b");
    idle();
`endif

    // Reset at the edge that samples a write hit discards it
    @(negedge clk);
    sel = 1'b1; rnw = 1'b0; abus = 32'h00; be = 4'hF; dbus = 32'h0BADF00D; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstabort.ack", 128'(ack), 128'(0));
    chk("rstabort.stb", 128'(stb), 128'(0));
    chk("rstabort.out", udo, mk(0, DB, DB, DB));
    @(negedge clk);
    sel = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstabort.ack2", 128'(ack), 128'(0));
    chk("rstabort.out2", udo, mk(0, DB, DB, DB));
    chk("sb.empty", 128'(sb_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/opb_register_bank_ppc2simulink.md
# opb_register_bank_ppc2simulink

Parametrised successor to the single software-to-fabric register. It is an OPB slave exposing `C_NUM_REGS` 32-bit PowerPC-writable control registers to Simulink user logic on one clock. It adds byte-enable writes, readback, per-register write strobes, self-clearing pulse registers, and an optional atomic shadow/commit mode. It sits between the OPB bus and user fabric, replacing banks of individual single-register instances.

## Interface

**Parameters**

- `C_BASEADDR`, default 32'h00000000: base byte address of the bank.
- `C_HIGHADDR`, default 32'h000000FF: top byte address; must cover `4*(C_NUM_REGS+1)` bytes.
- `C_OPB_AWIDTH`, default 32: OPB address width.
- `C_OPB_DWIDTH`, default 32: OPB data width; only 32 supported.
- `C_NUM_REGS`, default 4: register count, 1..63.
- `C_PULSE_MASK`, default 0: `C_NUM_REGS`-bit mask; bit i=1 makes register i self-clearing (pulse).
- `C_RESET_VAL`, default 32'h0: reset value of every non-pulse register.
- `C_FAMILY`, default "virtex6": target family, informational.

**Ports**

- `OPB_Clk`, in, 1: sole clock; bus and user side both run on it.
- `OPB_Rst_n`, in, 1: synchronous, active-low reset.
- `OPB_ABus`, in, [0:31]: byte address.
- `OPB_BE`, in, [0:3]: byte enables; `BE[0]` selects `DBus[0:7]`, the most significant byte.
- `OPB_DBus`, in, [0:31]: write data; OPB bit 0 maps to register bit 31.
- `OPB_RNW`, in, 1: 1 = read.
- `OPB_select`, in, 1: transaction request.
- `OPB_seqAddr`, in, 1: ignored.
- `Sl_DBus`, out, [0:31]: read data; zero except during a read ack.
- `Sl_xferAck`, out, 1: one-cycle transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup`, out, 1 each: tied 0.
- `user_data_out`, out, `32*C_NUM_REGS`: register i occupies bits `[32i+31:32i]`.
- `user_wr_stb`, out, `C_NUM_REGS`: bit i pulses one cycle when register i's output updates.

## Operation

- **Decode.** A transaction is a hit when `OPB_select` is high, `C_BASEADDR <= OPB_ABus <= C_HIGHADDR`, and `ack_q` is 0. Word index is `(OPB_ABus - C_BASEADDR) >> 2`; the low two address bits are ignored.
- **Write, index < `C_NUM_REGS`.** Each byte is updated where its `OPB_BE` bit is 1; the other bytes keep their value.
- **Pulse register written.** The merged value drives `user_data_out` for exactly one cycle, then returns to 0. A readback returns 0.
- **Read.** Returns the current register value (the shadow value when `REG_SHADOW_EN` is defined).
- **Out-of-range index** (index >= `C_NUM_REGS`, excluding the commit index when `REG_SHADOW_EN` is defined):
  - the transaction is acked;
  - writes are dropped;
  - reads return 0.
- **`user_wr_stb[i]`** pulses in the same cycle that register i's new value first appears on `user_data_out`. A write of an identical value still pulses.
- **Reset values.** All registers `C_RESET_VAL`; pulse registers 0. `user_wr_stb` 0, `Sl_DBus` 0, `Sl_xferAck` 0, all dirty bits 0.

## Timing

- A hit in cycle T gives `Sl_xferAck` = 1 in cycle T+1 only. Read data is valid on `Sl_DBus` in T+1 only.
- A write hit in T updates storage at the T→T+1 edge, so `user_data_out` and `user_wr_stb` show the change in T+1. Write latency is 1.
- The master holds `OPB_select` through T+1. `ack_q` blocks a second ack in T+1, so back-to-back transactions are acked at most every other cycle.
- If `OPB_Rst_n` is low at the edge ending T, the T+1 ack is suppressed, the write is discarded, and all state is reset.
- Pulse-register output is high for exactly one cycle. Two writes to it in consecutive transactions produce two separate one-cycle pulses.

## Configuration

- **`REG_SHADOW_EN` defined:**
  - writes land in per-register shadows and set a dirty bit; `user_data_out` is unchanged;
  - word index `C_NUM_REGS` is the commit register;
  - a write to it with register bit 0 = 1 copies every dirty shadow to its output in the same cycle, pulses `user_wr_stb` for the dirty registers only, and clears all dirty bits;
  - pulse registers pulse on commit;
  - a commit read returns the dirty mask.
- **`REG_SHADOW_EN` undefined:**
  - writes apply directly as described in Operation;
  - the commit index behaves as out-of-range.

## Test plan

- After reset, with `C_RESET_VAL`=32'hDEADBEEF and `C_NUM_REGS`=4, read index 2. Required: ack in the cycle after the hit, `Sl_DBus`=DEADBEEF in that cycle only, 0 afterwards.
- Write 32'h12345678 with `BE`=4'b0110 to index 1, which holds DEADBEEF. Required: `user_data_out[63:32]`=DE3456EF in T+1, `user_wr_stb`=4'b0010 for one cycle.
- With `C_PULSE_MASK`=4'b1000, write 32'hA5 to index 3. Required: `user_data_out[127:96]`=A5 for one cycle then 0; readback 0.
- Write to index 9. Required: acked, no output change, no strobe; a read of index 9 returns 0.
- Assert `OPB_Rst_n`=0 at the edge after a write hit. Required: no ack, registers at reset values.
- With `REG_SHADOW_EN`, write indices 0 and 2, then commit 32'h1. Required: no output change before the commit; on commit both update together, `user_wr_stb`=4'b0101, dirty mask reads 0.
